// File: rtl/feature_vector_builder_pkg.sv
// Shared constants and state type for the feature vector builder.
// Rounding quantization is selected by defining FVB_ROUND_EN; default is truncation.
package feature_vector_builder_pkg;

  localparam int VEC_ENTRIES = 64;
  localparam int ENTRY_W     = 4;
  localparam int SAMPLE_W    = 8;
  localparam int VEC_W       = 256;
  localparam int IDX_W       = 6;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } fvb_state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_ENTRIES - 1);

endpackage

// File: rtl/feature_vector_builder_if.sv
// Sample stream in, packed feature vector out, plus sticky truncation flag.
interface feature_vector_builder_if;
  import feature_vector_builder_pkg::*;

  logic [SAMPLE_W-1:0] in_data;
  logic                in_valid;
  logic                in_sof;
  logic                in_ready;
  logic [0:VEC_W-1]    test_vector;
  logic                out_valid;
  logic                out_ready;
  logic                frame_err;

  modport master (
    output in_data, in_valid, in_sof, out_ready,
    input  in_ready, test_vector, out_valid, frame_err
  );

  modport slave (
    input  in_data, in_valid, in_sof, out_ready,
    output in_ready, test_vector, out_valid, frame_err
  );

endinterface

// File: rtl/feature_vector_builder_quant.sv
// fvb_quant: 8-bit sample to 4-bit entry; FVB_ROUND_EN selects round-to-nearest
// with saturation, otherwise the upper nibble is taken.
module fvb_quant
  import feature_vector_builder_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [ENTRY_W-1:0]  q_o
);

`ifdef FVB_ROUND_EN
  logic [SAMPLE_W:0] sum;
  logic              unused_low;

  assign sum        = {1'b0, sample_i} + 9'd8;
  // Carry into bit 8 means the rounded value reached 16, so clamp to 15.
  assign q_o        = sum[SAMPLE_W] ? 4'hF : sum[7:4];
  assign unused_low = ^sum[3:0];
`else
  logic unused_low;

  assign q_o        = sample_i[7:4];
  assign unused_low = ^sample_i[3:0];
`endif

endmodule

// File: rtl/feature_vector_builder.sv
// Collects 64 quantized samples into a packed vector and holds it until consumed.
// Quantizer mode follows FVB_ROUND_EN (see fvb_quant).
module feature_vector_builder
  import feature_vector_builder_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  feature_vector_builder_if.slave  bus
);

  fvb_state_t         state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               frame_err_q;

  logic [ENTRY_W-1:0] q_sample;
  logic               transfer;
  logic               resync;
  logic [IDX_W-1:0]   wr_idx;

  fvb_quant u_quant (
    .sample_i (bus.in_data),
    .q_o      (q_sample)
  );

  assign transfer = bus.in_valid && (state_q == FILL);
  // An in_sof mid-frame restarts the frame with this sample as entry 0.
  assign resync   = transfer && bus.in_sof && (idx_q != '0);
  assign wr_idx   = resync ? '0 : idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (transfer) begin
            if (resync) begin
              idx_q       <= IDX_W'(1);
              frame_err_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              if (idx_q == LAST_IDX) begin
                state_q <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_q <= FILL;
            idx_q   <= '0;
          end
        end
        default: begin
          state_q <= FILL;
          idx_q   <= '0;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < VEC_ENTRIES; gi++) begin : g_entry
      logic [ENTRY_W-1:0] entry_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_q <= '0;
        end else if (transfer && (wr_idx == IDX_W'(gi))) begin
          entry_q <= q_sample;
        end
      end

      // Ascending vector range puts entry MSB at bit gi*4.
      assign bus.test_vector[gi*ENTRY_W +: ENTRY_W] = entry_q;
    end
  endgenerate

  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_feature_vector_builder.sv
// Directed bench for feature_vector_builder; expectations follow FVB_ROUND_EN.
module tb_feature_vector_builder;
  import feature_vector_builder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  feature_vector_builder_if bus ();

  feature_vector_builder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [0:VEC_W-1] exp_vec;

  function automatic logic [3:0] qexp(input logic [7:0] x);
    int r;
`ifdef FVB_ROUND_EN
    r = (int'(x) + 8) / 16;
    if (r > 15) r = 15;
`else
    r = int'(x) / 16;
`endif
    return 4'(r);
  endfunction

  task automatic send(input logic [7:0] d, input logic sof);
    int n = 0;
    @(negedge clk);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%0b required=1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    $display("xfer data=%02h sof=%0b out_valid=%0b", d, sof, bus.out_valid);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.test_vector !== '0) begin errors++; $display("FAIL reset_vec got=%h required=0", bus.test_vector); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b required=0", bus.out_valid); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b required=0", bus.frame_err); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b required=1", bus.in_ready); end
  endtask

  task automatic test_frame_pass();
    int early = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      exp_vec[i*4 +: 4] = 4'(i % 16);
      send(8'((i % 16) * 16), 1'b0);
      if (i < 63 && bus.out_valid) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL pass_early_valid got=%0d required=0", early); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL pass_out_valid got=%b required=1", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL pass_in_ready_hold got=%b required=0", bus.in_ready); end
    checks++; if (bus.test_vector !== exp_vec) begin errors++; $display("FAIL pass_vec got=%h required=%h", bus.test_vector, exp_vec); end
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL pass_bubble out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_rounding();
    logic [7:0] d;
    exp_vec = '0;
`ifdef FVB_ROUND_EN
    exp_vec[0:11] = 12'h01F;
`else
    exp_vec[0:11] = 12'h00F;
`endif
    bus.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      d = (i == 0) ? 8'h07 : (i == 1) ? 8'h08 : (i == 2) ? 8'hF8 : 8'h00;
      send(d, 1'b0);
    end
    checks++; if (bus.test_vector !== exp_vec) begin errors++; $display("FAIL round_vec got=%h required=%h", bus.test_vector, exp_vec); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    int hs = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      d = 8'(i * 37 + 5);
      exp_vec[i*4 +: 4] = qexp(d);
      send(d, 1'b0);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = 8'hFF; bus.in_sof = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c=%0d got=%b required=0", c, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid c=%0d got=%b required=1", c, bus.out_valid); end
      checks++; if (bus.test_vector !== exp_vec) begin errors++; $display("FAIL bp_vec c=%0d got=%h required=%h", c, bus.test_vector, exp_vec); end
    end
    bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (bus.out_valid && bus.out_ready) hs++;
      @(negedge clk);
    end
    $display("release handshakes=%0d", hs);
    checks++; if (hs != 1) begin errors++; $display("FAIL bp_handshakes got=%0d required=1", hs); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL bp_frame_err got=%b required=0", bus.frame_err); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got=%b required=1", bus.in_ready); end
  endtask

  task automatic test_resync();
    logic [7:0] d;
    int early = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 30; i++) send(8'(i * 5), 1'b0);
    send(8'hA5, 1'b1);
    exp_vec[0:3] = qexp(8'hA5);
    checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL resync_frame_err got=%b required=1", bus.frame_err); end
    for (int j = 1; j < 64; j++) begin
      d = 8'(255 - j * 4);
      exp_vec[j*4 +: 4] = qexp(d);
      send(d, 1'b0);
      if (j < 63 && bus.out_valid) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL resync_early_valid got=%0d required=0", early); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL resync_out_valid got=%b required=1", bus.out_valid); end
    checks++; if (bus.test_vector !== exp_vec) begin errors++; $display("FAIL resync_vec got=%h required=%h", bus.test_vector, exp_vec); end
    @(posedge clk);
    #1;
    checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL resync_sticky got=%b required=1", bus.frame_err); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int early = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) send(8'hFF, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    checks++; if (bus.test_vector !== '0) begin errors++; $display("FAIL rstmid_vec got=%h required=0", bus.test_vector); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b required=0", bus.out_valid); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_frame_err got=%b required=0", bus.frame_err); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      d = 8'(i * 4);
      exp_vec[i*4 +: 4] = qexp(d);
      send(d, 1'b0);
      if (i < 63 && bus.out_valid) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL rstmid_early_valid got=%0d required=0", early); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_out_valid_after got=%b required=1", bus.out_valid); end
    checks++; if (bus.test_vector !== exp_vec) begin errors++; $display("FAIL rstmid_vec_after got=%h required=%h", bus.test_vector, exp_vec); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_gapped();
    int early = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      exp_vec[i*4 +: 4] = 4'(i % 16);
      send(8'((i % 16) * 16), 1'b0);
      if (i < 63) begin
        if (bus.out_valid) early++;
        @(negedge clk);
      end
    end
    checks++; if (early != 0) begin errors++; $display("FAIL gap_early_valid got=%0d required=0", early); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL gap_out_valid got=%b required=1", bus.out_valid); end
    checks++; if (bus.test_vector !== exp_vec) begin errors++; $display("FAIL gap_vec got=%h required=%h", bus.test_vector, exp_vec); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b0;
    exp_vec       = '0;
    test_reset();
    test_frame_pass();
    test_rounding();
    test_backpressure();
    test_resync();
    test_reset_mid();
    test_gapped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
